// File: rtl/bcd_display_pkg.sv
// Shared constants and types for the two-digit multiplexed 7-segment driver.
// Segment codes are ordered {g,f,e,d,c,b,a}, active high.
package bcd_display_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    typedef enum logic [1:0] {
        StShow = 2'd0,
        StOff  = 2'd1,
        StOn   = 2'd2
    } flash_state_e;

endpackage

// File: rtl/bcd_display_mux_bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder; non-decimal codes show a dash.
module bcd_to_seg7
    import bcd_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_mux.sv
// Two-digit multiplexed common-cathode driver with anti-ghost blanking,
// leading-zero suppression and a post-load flash sequence.
module bcd_display_mux
    import bcd_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 32,
    parameter int unsigned BLANK_CYCLES = 2,
    parameter int unsigned FLASH_PERIOD = 4096,
    parameter int unsigned FLASH_COUNT  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] digit10,
    input  logic [3:0] digit1,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       busy
);

    localparam logic [7:0]  RC_LAST    = 8'(REFRESH_DIV - 1);
    localparam logic [7:0]  BLANK      = 8'(BLANK_CYCLES);
    localparam logic [15:0] TIMER_LOAD = 16'(FLASH_PERIOD - 1);
    localparam bit          FLASH_EN   = (FLASH_COUNT > 0);
    localparam logic [7:0]  PAIRS_LOAD = FLASH_EN ? 8'(FLASH_COUNT - 1) : 8'd0;

    logic [3:0]   tens_q, units_q;
    logic [7:0]   rc_q;
    logic         slot_q;
    flash_state_e state_q;
    logic [15:0]  timer_q;
    logic [7:0]   pairs_q;

    logic [3:0] digit_mux;
    logic [6:0] seg_dec;
    logic       visible, lit, suppress;
    logic [1:0] an_d;
    logic [6:0] seg_d;

    assign digit_mux = slot_q ? tens_q : units_q;

    bcd_to_seg7 u_dec (
        .bcd (digit_mux),
        .seg (seg_dec)
    );

    // Only the tens digit is ever suppressed, so "00" still shows one zero.
    always_comb begin
        visible  = (rc_q >= BLANK);
        lit      = (state_q != StOff);
        suppress = slot_q && blank_lz && (tens_q == 4'd0);
        an_d     = 2'b00;
        if (visible && lit && !suppress) begin
            an_d = slot_q ? 2'b10 : 2'b01;
        end
        seg_d = (an_d != 2'b00) ? seg_dec : SEG_OFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg     <= SEG_OFF;
            an      <= 2'b00;
            busy    <= 1'b0;
            tens_q  <= 4'd0;
            units_q <= 4'd0;
            rc_q    <= 8'd0;
            slot_q  <= 1'b0;
            state_q <= StShow;
            timer_q <= 16'd0;
            pairs_q <= 8'd0;
        end else begin
            seg  <= seg_d;
            an   <= an_d;
            busy <= (state_q != StShow);

            if (rc_q == RC_LAST) begin
                rc_q   <= 8'd0;
                slot_q <= ~slot_q;
            end else begin
                rc_q <= rc_q + 8'd1;
            end

            if (load) begin
                tens_q  <= digit10;
                units_q <= digit1;
            end

            // A load restarts the sequence and wins over a same-cycle expiry.
            if (load && FLASH_EN) begin
                state_q <= StOff;
                timer_q <= TIMER_LOAD;
                pairs_q <= PAIRS_LOAD;
            end else begin
                unique case (state_q)
                    StShow: ;
                    StOff: begin
                        if (timer_q == 16'd0) begin
                            state_q <= StOn;
                            timer_q <= TIMER_LOAD;
                        end else begin
                            timer_q <= timer_q - 16'd1;
                        end
                    end
                    StOn: begin
                        if (timer_q == 16'd0) begin
                            if (pairs_q != 8'd0) begin
                                state_q <= StOff;
                                timer_q <= TIMER_LOAD;
                                pairs_q <= pairs_q - 8'd1;
                            end else begin
                                state_q <= StShow;
                            end
                        end else begin
                            timer_q <= timer_q - 16'd1;
                        end
                    end
                    default: state_q <= StShow;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed bench for bcd_display_mux: refresh/blanking, decode, suppression,
// flash timing, restart and asynchronous reset.
module tb_bcd_display_mux;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load0 = 1'b0;
    logic       load1 = 1'b0;
    logic       blank_lz = 1'b0;
    logic [3:0] digit10 = 4'd0;
    logic [3:0] digit1 = 4'd0;

    logic [6:0] seg0, seg1;
    logic [1:0] an0, an1;
    logic       busy0, busy1;

    int k;
    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Edges since reset release; outputs after edge k reflect the state after edge k-1.
    always @(posedge clk or posedge rst) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    bcd_display_mux u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .load     (load0),
        .digit10  (digit10),
        .digit1   (digit1),
        .blank_lz (blank_lz),
        .seg      (seg0),
        .an       (an0),
        .busy     (busy0)
    );

    bcd_display_mux #(.FLASH_COUNT(0)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .load     (load1),
        .digit10  (digit10),
        .digit1   (digit1),
        .blank_lz (blank_lz),
        .seg      (seg1),
        .an       (an1),
        .busy     (busy1)
    );

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s k=%0d: observed %h expected %h", tag, k, got, want);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_seg0"}, seg0, 7'h00);
        check({tag, "_an0"}, {5'd0, an0}, 7'h00);
        check({tag, "_busy0"}, {6'd0, busy0}, 7'h00);
        check({tag, "_seg1"}, seg1, 7'h00);
        check({tag, "_an1"}, {5'd0, an1}, 7'h00);
        check({tag, "_busy1"}, {6'd0, busy1}, 7'h00);
    endtask

    // Check n consecutive edges of one DUT against the refresh/decode model.
    task automatic check_disp(input string tag, input int n, input bit d,
                              input logic [3:0] t, input logic [3:0] u,
                              input bit lit, input bit bsy);
        int s, rc, slot;
        logic [1:0] ea;
        logic [6:0] es;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            s    = k - 1;
            rc   = s % 32;
            slot = (s / 32) % 2;
            ea   = 2'b00;
            if (lit && rc >= 2 && !(slot == 1 && blank_lz && t == 4'd0)) begin
                ea = (slot == 1) ? 2'b10 : 2'b01;
            end
            es = (ea != 2'b00) ? ref_seg((slot == 1) ? t : u) : 7'h00;
            check({tag, "_an"}, {5'd0, d ? an1 : an0}, {5'd0, ea});
            check({tag, "_seg"}, d ? seg1 : seg0, es);
            check({tag, "_busy"}, {6'd0, d ? busy1 : busy0}, {6'd0, bsy});
        end
    endtask

    task automatic do_load(input bit d, input logic [3:0] t, input logic [3:0] u);
        @(negedge clk);
        digit10 = t;
        digit1  = u;
        if (d) load1 = 1'b1;
        else   load0 = 1'b1;
        @(negedge clk);
        load0 = 1'b0;
        load1 = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset("in_reset");
        @(negedge clk);
        rst = 1'b0;

        check_disp("idle", 70, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);

        do_load(1'b1, 4'd4, 4'd2);
        check_disp("show42", 64, 1'b1, 4'd4, 4'd2, 1'b1, 1'b0);

        blank_lz = 1'b1;
        do_load(1'b1, 4'd0, 4'd7);
        check_disp("lz07", 64, 1'b1, 4'd0, 4'd7, 1'b1, 1'b0);
        do_load(1'b1, 4'd0, 4'd0);
        check_disp("lz00", 64, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0);
        blank_lz = 1'b0;

        do_load(1'b1, 4'd12, 4'd15);
        check_disp("dash", 64, 1'b1, 4'd12, 4'd15, 1'b1, 1'b0);

        do_load(1'b0, 4'd1, 4'd9);
        for (int i = 0; i < 6; i++) begin
            check_disp("flash", 4096, 1'b0, 4'd1, 4'd9, (i % 2) == 1, 1'b1);
        end
        check_disp("flash_end", 4, 1'b0, 4'd1, 4'd9, 1'b1, 1'b0);

        do_load(1'b0, 4'd1, 4'd9);
        check_disp("pre_off", 4096, 1'b0, 4'd1, 4'd9, 1'b0, 1'b1);
        check_disp("pre_on", 1903, 1'b0, 4'd1, 4'd9, 1'b1, 1'b1);
        do_load(1'b0, 4'd5, 4'd6);
        for (int i = 0; i < 6; i++) begin
            check_disp("restart", 4096, 1'b0, 4'd5, 4'd6, (i % 2) == 1, 1'b1);
        end
        check_disp("restart_end", 4, 1'b0, 4'd5, 4'd6, 1'b1, 1'b0);

        do_load(1'b0, 4'd2, 4'd3);
        check_disp("pre_rst", 100, 1'b0, 4'd2, 4'd3, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset("async_rst");
        @(negedge clk);
        rst = 1'b0;
        check_disp("post_rst0", 70, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
